// File: rtl/axi_dma_pkg.sv
// Shared types for the AXI DMA performance-monitoring path.
//   dma_perf_t    : free-running counter bus from the perf-counter stage
//   perf_sample_t : one closed-window record (index tag + four 32-bit deltas)
package axi_dma_pkg;

    localparam int unsigned PerfMinWindow = 2;
    localparam int unsigned PerfIdxWidth  = 16;

    typedef struct packed {
        logic [31:0] r_bw;
        logic [31:0] w_bw;
        logic [31:0] dma_busy_cnt;
        logic [31:0] completed_id;
    } dma_perf_t;

    typedef struct packed {
        logic [PerfIdxWidth-1:0] idx;
        logic [31:0]             r_bytes;
        logic [31:0]             w_bytes;
        logic [31:0]             busy;
        logic [31:0]             xfers;
    } perf_sample_t;

    // Differences are modulo 2^32, so an upstream counter wrap still yields the true delta.
    function automatic perf_sample_t perf_delta(input dma_perf_t cur, input dma_perf_t base,
                                                input logic [PerfIdxWidth-1:0] idx);
        perf_sample_t s;
        s.idx     = idx;
        s.r_bytes = cur.r_bw         - base.r_bw;
        s.w_bytes = cur.w_bw         - base.w_bw;
        s.busy    = cur.dma_busy_cnt - base.dma_busy_cnt;
        s.xfers   = cur.completed_id - base.completed_id;
        return s;
    endfunction

endpackage

// File: rtl/axi_dma_perf_sample_fifo.sv
// Small synchronous FIFO of perf_sample_t records.
//   clk_i, rst_i (sync, active-high), flush_i (empties FIFO)
//   push_i/data_i   : write; accepted when not full, or when full with a pop in the same cycle
//   pop_i/data_o    : read of head; ignored while empty; data_o is zero while empty
//   full_o, empty_o, fill_o : occupancy status
module axi_dma_perf_sample_fifo
    import axi_dma_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  perf_sample_t             data_i,
    input  logic                     pop_i,
    output perf_sample_t             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    perf_sample_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign fill_o  = count_q;
    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_dma_perf_window.sv
// Converts free-running DMA perf counters into per-window delta samples.
//   clk_i, rst_i (sync, active-high)
//   enable_i        : windowing active; rising edge starts a fresh window
//   clear_i         : flush FIFO, clear overflow/drop count, restart window index
//   window_cycles_i : window length (min 2), latched on enable rising edge
//   dma_perf_i      : counter bus
//   sample_o/sample_valid_o/sample_ready_i : head-of-FIFO record, valid/ready drain
//   fill_o, overflow_o (sticky), drop_cnt_o (saturating) : FIFO status
module axi_dma_perf_window
    import axi_dma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [31:0]                   window_cycles_i,
    input  dma_perf_t                     dma_perf_i,
    output perf_sample_t                  sample_o,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          overflow_o,
    output logic [15:0]                   drop_cnt_o
);

    logic                 en_q;
    logic [31:0]          timer_q;
    logic [31:0]          win_len_q;
    logic [31:0]          win_len_next;
    dma_perf_t            base_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 overflow_q;
    logic [15:0]          drop_q;

    logic                 start;
    logic                 running;
    logic                 close;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    perf_sample_t         record;

    assign start        = enable_i & ~en_q;
    assign running      = enable_i & en_q;
    assign close        = running & (timer_q == win_len_q - 32'd1);
    // A window closing together with clear_i is discarded.
    assign push         = close & ~clear_i;
    assign pop          = sample_valid_o & sample_ready_i;
    assign drop         = push & fifo_full & ~pop;
    assign win_len_next = (window_cycles_i < 32'(PerfMinWindow)) ? 32'(PerfMinWindow)
                                                                 : window_cycles_i;
    assign record       = perf_delta(dma_perf_i, base_q, PerfIdxWidth'(idx_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            timer_q    <= '0;
            win_len_q  <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            en_q <= enable_i;
            if (start) win_len_q <= win_len_next;
            if (clear_i) begin
                overflow_q <= 1'b0;
                drop_q     <= '0;
                idx_q      <= '0;
                if (enable_i) begin
                    base_q  <= dma_perf_i;
                    timer_q <= '0;
                end
            end else begin
                // Close re-baselines on the same edge so windows are back-to-back.
                if (start || close) begin
                    base_q  <= dma_perf_i;
                    timer_q <= '0;
                    if (close) idx_q <= idx_q + 1'b1;
                end else if (running) begin
                    timer_q <= timer_q + 32'd1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_q != '1) drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    axi_dma_perf_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (push),
        .data_i  (record),
        .pop_i   (pop),
        .data_o  (sample_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill_o)
    );

    assign sample_valid_o = ~fifo_empty;
    assign overflow_o     = overflow_q;
    assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_axi_dma_perf_window.sv
module tb_axi_dma_perf_window;
    import axi_dma_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         clear;
    logic [31:0]  window_cycles;
    dma_perf_t    perf;
    perf_sample_t sample;
    logic         sample_valid;
    logic         sample_ready;
    logic [2:0]   fill;
    logic         overflow;
    logic [15:0]  drop_cnt;

    axi_dma_perf_window #(
        .FIFO_DEPTH (4),
        .IDX_WIDTH  (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .clear_i         (clear),
        .window_cycles_i (window_cycles),
        .dma_perf_i      (perf),
        .sample_o        (sample),
        .sample_valid_o  (sample_valid),
        .sample_ready_i  (sample_ready),
        .fill_o          (fill),
        .overflow_o      (overflow),
        .drop_cnt_o      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] win;
        logic [31:0] r_inc;
        logic [31:0] w_inc;
        logic [31:0] b_inc;
        logic [31:0] x_inc;
        int          nwin;
    } vec_t;

    vec_t         vecs [4];
    perf_sample_t exp_q [$];
    int           checks = 0;
    int           errors = 0;
    logic [15:0]  exp_idx = '0;
    logic [31:0]  r_inc = '0, w_inc = '0, b_inc = '0, x_inc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input perf_sample_t act, input perf_sample_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL sample: got idx=%0h r=%0h w=%0h b=%0h x=%0h expected idx=%0h r=%0h w=%0h b=%0h x=%0h",
                     act.idx, act.r_bytes, act.w_bytes, act.busy, act.xfers,
                     exp.idx, exp.r_bytes, exp.w_bytes, exp.busy, exp.xfers);
        end
    endtask

    // Expected record for a window of 'len' cycles with the current increments.
    task automatic expect_win(input logic [31:0] len);
        perf_sample_t e;
        e.idx     = exp_idx;
        e.r_bytes = len * r_inc;
        e.w_bytes = len * w_inc;
        e.busy    = len * b_inc;
        e.xfers   = len * x_inc;
        exp_q.push_back(e);
        exp_idx++;
    endtask

    // One clock: scoreboard check of any handshake before the edge, counters advance after it.
    task automatic step();
        perf_sample_t e;
        @(negedge clk);
        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", {16'h0, sample.idx}, 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk_rec(sample, e);
            end
        end
        @(posedge clk);
        #1;
        perf.r_bw         += r_inc;
        perf.w_bw         += w_inc;
        perf.dma_busy_cnt += b_inc;
        perf.completed_id += x_inc;
    endtask

    initial begin
        logic [31:0] eff;
        vecs[0] = '{win: 10, r_inc: 8,  w_inc: 0,  b_inc: 1, x_inc: 0, nwin: 2};
        vecs[1] = '{win: 0,  r_inc: 4,  w_inc: 3,  b_inc: 1, x_inc: 1, nwin: 3};
        vecs[2] = '{win: 1,  r_inc: 2,  w_inc: 5,  b_inc: 0, x_inc: 1, nwin: 2};
        vecs[3] = '{win: 7,  r_inc: 16, w_inc: 32, b_inc: 1, x_inc: 1, nwin: 2};

        rst = 1'b1; enable = 1'b0; clear = 1'b0; window_cycles = 32'd10;
        perf = '0; sample_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_fill", 64'(fill), 0);
        chk("reset_valid", 64'(sample_valid), 0);
        chk("reset_overflow", 64'(overflow), 0);
        chk("reset_drop", 64'(drop_cnt), 0);
        chk("reset_sample", 64'(sample.r_bytes), 0);

        // Table-driven windows, consumer always ready.
        sample_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            window_cycles = vecs[v].win;
            r_inc = vecs[v].r_inc; w_inc = vecs[v].w_inc;
            b_inc = vecs[v].b_inc; x_inc = vecs[v].x_inc;
            eff = (vecs[v].win < 2) ? 32'd2 : vecs[v].win;
            enable = 1'b1;
            step();
            chk("no_sample_at_start", 64'(sample_valid), 0);
            for (int w = 0; w < vecs[v].nwin; w++) begin
                expect_win(eff);
                for (int c = 0; c < int'(eff) - 1; c++) step();
                chk("valid_before_close", 64'(sample_valid), 0);
                step();
                chk("valid_after_close", 64'(sample_valid), 1);
            end
            enable = 1'b0;
            step(); step();
        end

        // Upstream counter wrap inside a window.
        r_inc = 8; w_inc = 0; b_inc = 0; x_inc = 0;
        perf.r_bw = 32'hFFFF_FFF0;
        window_cycles = 4;
        exp_q.push_back('{idx: exp_idx, r_bytes: 32'h20, w_bytes: 0, busy: 0, xfers: 0});
        exp_idx++;
        enable = 1'b1;
        step();
        repeat (4) step();
        chk("wrap_valid", 64'(sample_valid), 1);
        enable = 1'b0;
        step(); step();

        // Overflow: 6 windows into a 4-deep FIFO with no consumer.
        r_inc = 1; w_inc = 2; b_inc = 1; x_inc = 0;
        window_cycles = 3;
        sample_ready = 1'b0;
        enable = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) expect_win(3);
            else exp_idx++;
            repeat (3) step();
        end
        chk("ovf_fill", 64'(fill), 4);
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_drop", 64'(drop_cnt), 2);

        // Full FIFO, pop on the close edge: both succeed.
        expect_win(3);
        repeat (2) step();
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        enable = 1'b0;
        chk("fullpp_fill", 64'(fill), 4);
        chk("fullpp_drop", 64'(drop_cnt), 2);
        sample_ready = 1'b1;
        repeat (6) step();
        chk("drain_fill", 64'(fill), 0);
        chk("ovf_sticky", 64'(overflow), 1);

        // Clear on a close cycle.
        window_cycles = 5;
        sample_ready = 1'b0;
        enable = 1'b1;
        step();
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_fill", 64'(fill), 0);
        chk("clear_valid", 64'(sample_valid), 0);
        chk("clear_overflow", 64'(overflow), 0);
        chk("clear_drop", 64'(drop_cnt), 0);
        exp_idx = '0;
        expect_win(5);
        sample_ready = 1'b1;
        repeat (4) step();
        chk("clear_no_early", 64'(sample_valid), 0);
        step();
        chk("clear_next_valid", 64'(sample_valid), 1);
        enable = 1'b0;
        step(); step();

        // Stop mid-window: partial window discarded.
        window_cycles = 10;
        enable = 1'b1;
        step();
        repeat (5) step();
        enable = 1'b0;
        repeat (12) step();
        chk("stop_fill", 64'(fill), 0);
        chk("stop_valid", 64'(sample_valid), 0);

        // Reset mid-window with one sample buffered.
        window_cycles = 4;
        sample_ready = 1'b0;
        enable = 1'b1;
        step();
        expect_win(4);
        repeat (4) step();
        chk("pre_reset_fill", 64'(fill), 1);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        enable = 1'b0;
        chk("midrst_fill", 64'(fill), 0);
        chk("midrst_valid", 64'(sample_valid), 0);
        chk("midrst_overflow", 64'(overflow), 0);
        chk("midrst_drop", 64'(drop_cnt), 0);
        chk("midrst_sample", 64'(sample.r_bytes), 0);
        exp_q.delete();
        sample_ready = 1'b1;
        repeat (6) step();
        chk("final_fill", 64'(fill), 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
